// File: rtl/traffic_lamp_guard.sv
// traffic_lamp_guard: safety stage between the traffic light controller and
// the lamp drivers. It registers the controller's NS/EW {R,Y,G} lamp codes and
// passes them through. It also checks for illegal codes, conflicting greens and
// bad yellow sequencing. On a violation it latches a fault code and drives a
// failsafe red pattern until fault_clr is asserted.
// Build option: define TRAFFIC_GUARD_FLASH_EN to make the failsafe red flash
// (FLASH_HALF cycles on, FLASH_HALF off). Without it, red is held steady.
module traffic_lamp_guard #(
  parameter int MIN_YEL    = 2,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ns_in,
  input  logic [2:0] ew_in,
  input  logic       fault_clr,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam int         YW  = $clog2(MIN_YEL + 1);
  localparam logic [YW-1:0] MIN_YEL_C = YW'(MIN_YEL);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  ns_lamp_q, ns_lamp_d, ew_lamp_q, ew_lamp_d;
  logic        fault_q, fault_d;
  logic [2:0]  code_q, code_d;
  logic [YW-1:0] ns_ycnt_q, ns_ycnt_d, ew_ycnt_q, ew_ycnt_d;
  logic [2:0]  viol_code;
  logic [2:0]  fault_pat;

  function automatic logic onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic [YW-1:0] ycnt_next(input logic [2:0] lamp,
                                              input logic [YW-1:0] cnt);
    if (lamp != YEL)        return '0;
    else if (cnt == MIN_YEL_C) return cnt;
    else                    return cnt + 1'b1;
  endfunction

  // Violation check on the incoming codes against the currently driven lamps.
  always_comb begin
    logic ill, conflict, skip, short_y;
    ill      = !onehot3(ns_in) || !onehot3(ew_in);
    conflict = (ns_in != RED) && (ew_in != RED);
    skip     = (ns_lamp_q == GRN && ns_in == RED) ||
               (ew_lamp_q == GRN && ew_in == RED);
    short_y  = (ns_lamp_q == YEL && ns_in == RED && ns_ycnt_q < MIN_YEL_C) ||
               (ew_lamp_q == YEL && ew_in == RED && ew_ycnt_q < MIN_YEL_C);
    // The lowest code wins when several checks fire, including across directions.
    if (ill)           viol_code = 3'd1;
    else if (conflict) viol_code = 3'd2;
    else if (skip)     viol_code = 3'd3;
    else if (short_y)  viol_code = 3'd4;
    else               viol_code = 3'd0;
  end

`ifdef TRAFFIC_GUARD_FLASH_EN
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_on_q, flash_on_d;

  // Flash timer: runs only in FAULT and restarts in the on phase when the fault is cleared.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    flash_on_d  = flash_on_q;
    if (state_q == ST_FAULT) begin
      if (fault_clr) begin
        flash_cnt_d = '0;
        flash_on_d  = 1'b1;
      end else if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d = '0;
        flash_on_d  = !flash_on_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
      end
    end
  end

  // Flash timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
    end
  end

  assign fault_pat = flash_on_d ? RED : 3'b000;
`else
  assign fault_pat = RED;
`endif

  // Next-state and lamp logic for the INIT / RUN / FAULT controller.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d   = state_q;
    ns_lamp_d = ns_lamp_q;
    ew_lamp_d = ew_lamp_q;
    fault_d   = fault_q;
    code_d    = code_q;
    ns_ycnt_d = ns_ycnt_q;
    ew_ycnt_d = ew_ycnt_q;
    unique case (state_q)
      ST_INIT: begin
        ns_lamp_d = RED;
        ew_lamp_d = RED;
        fault_d   = 1'b0;
        code_d    = '0;
        ns_ycnt_d = '0;
        ew_ycnt_d = '0;
        if (ns_in == RED && ew_in == RED) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (viol_code != 3'd0) begin
          // The faulty value is never driven. Failsafe starts in the on phase.
          state_d   = ST_FAULT;
          ns_lamp_d = RED;
          ew_lamp_d = RED;
          fault_d   = 1'b1;
          code_d    = viol_code;
        end else begin
          ns_lamp_d = ns_in;
          ew_lamp_d = ew_in;
          ns_ycnt_d = ycnt_next(ns_in, ns_ycnt_q);
          ew_ycnt_d = ycnt_next(ew_in, ew_ycnt_q);
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d   = ST_INIT;
          ns_lamp_d = RED;
          ew_lamp_d = RED;
          fault_d   = 1'b0;
          code_d    = '0;
        end else begin
          ns_lamp_d = fault_pat;
          ew_lamp_d = fault_pat;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and output registers.
  // NOTE: async active-low reset drives every output register to its safe value
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      ns_lamp_q <= RED;
      ew_lamp_q <= RED;
      fault_q   <= 1'b0;
      code_q    <= '0;
      ns_ycnt_q <= '0;
      ew_ycnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q   <= state_d;
      ns_lamp_q <= ns_lamp_d;
      ew_lamp_q <= ew_lamp_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      ns_ycnt_q <= ns_ycnt_d;
      ew_ycnt_q <= ew_ycnt_d;
    end
  end

  assign ns_lamp    = ns_lamp_q;
  assign ew_lamp    = ew_lamp_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: doc/traffic_lamp_guard.md
Name: traffic_lamp_guard

Overview:
- Downstream safety stage between the traffic light controller's NS/EW RYG outputs and the physical lamp drivers.
- Registers the controller's lamp codes and passes them through to the lamps.
- Checks every cycle for illegal codes, conflicting greens and bad phase sequencing.
- On any violation, blocks the faulty value, latches a fault code and forces a failsafe red pattern until software clears it.

Parameters:
- MIN_YEL, 2: minimum consecutive cycles a direction must show yellow before turning red.
- FLASH_HALF, 4: half-period of the failsafe red flash, in clk cycles.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ns_in  in  3  NS lamp code from controller; {R,Y,G}, bit2=R, bit0=G.
- ew_in  in  3  EW lamp code from controller; same encoding.
- fault_clr  in  1  level; acknowledges a latched fault.
- ns_lamp  out  3  registered NS lamp drive {R,Y,G}.
- ew_lamp  out  3  registered EW lamp drive {R,Y,G}.
- fault  out  1  high while in FAULT state.
- fault_code  out  3  first violation since last clear; 0 = none.

Behaviour:
- Reset (rst=0, async):
  - ns_lamp=ew_lamp=3'b100, fault=0, fault_code=0.
  - State=INIT, yellow counters=0, flash counter=0, flash phase=on.
- Outputs are registers.
  - In RUN, latency is 1 cycle: the value on ns_in/ew_in before edge k appears on the lamps after edge k.
- States:
  - INIT: lamps held 100/100. Go to RUN at the first edge where ns_in==100 and ew_in==100; those values load into the lamps.
  - RUN: each edge, evaluate checks on current inputs against the registered lamps (previous value) and the yellow counters.
    - No violation: lamps <= inputs.
    - Violation: go to FAULT. Lamps take the failsafe pattern; the faulty value is never driven. fault<=1, fault_code<=highest-priority code.
  - FAULT:
    - fault=1, fault_code held.
    - Lamps both 100 for FLASH_HALF cycles, then both 000 for FLASH_HALF cycles, repeating; the first FAULT cycle is the on phase.
    - fault_clr=1 at an edge: go to INIT, lamps<=100/100, fault<=0, fault_code<=0, flash counter reset.
- Checks, per direction, priority highest first:
  - code 1 ILLEGAL: input not one-hot (000, or 2+ bits set).
  - code 2 CONFLICT: both inputs non-red simultaneously.
  - code 3 SKIP_YEL: previous lamp G (001), input R (100).
  - code 4 SHORT_YEL: previous lamp Y (010), input R, and that direction's yellow counter < MIN_YEL.
- Legal transitions:
  - Any code unchanged is legal.
  - R->G, G->Y and Y->R (with counter >= MIN_YEL) are legal.
  - R->Y and Y->G are legal; sequencing of green/yellow entry is the controller's responsibility.
- Yellow counter (per direction):
  - Width $clog2(MIN_YEL+1).
  - Increments at each RUN edge where the accepted lamp value is Y, saturating at MIN_YEL.
  - Clears when the accepted value is not Y.
  - Held in FAULT; cleared on entry to INIT.
- Simultaneous events:
  - Violations on both directions in the same cycle: lowest code number wins.
  - fault_clr in INIT or RUN is ignored.
  - fault_clr held high continuously: FAULT lasts exactly one cycle, then INIT.
- Reset asserted mid-FAULT or mid-yellow: immediate return to reset values. No fault history survives reset.

Optional Feature:
- Macro TRAFFIC_GUARD_FLASH_EN.
- Defined: FAULT lamps flash red as described above.
- Not defined:
  - FAULT lamps held steady 100/100.
  - The flash counter and flash phase logic are not synthesized.
  - All other behaviour is identical.

Test Plan:
- Reset, then drive ns_in=ew_in=100 for 1 cycle -> state RUN; lamps 100/100 one cycle later; fault=0.
- Normal cycle, MIN_YEL=2: NS 001 x5, 010 x2, 100; EW 100 throughout -> lamps follow with 1-cycle lag; fault stays 0.
- In RUN, drive ns_in=001 with ew_in=001 -> next edge fault=1, fault_code=2; lamps 100/100 for 4 cycles, then 000/000 for 4, repeating (flash build).
- NS G (001) directly to R (100) -> fault_code=3; lamps never show the transition.
- NS yellow held 1 cycle, then R -> fault_code=4.
- In FAULT, pulse fault_clr, then hold inputs 100/100 -> INIT, then RUN; fault=0, fault_code=0.
- Assert rst low asynchronously mid-FAULT -> lamps 100/100 and fault=0 without waiting for a clock edge.
- ns_in=011 with ew_in=001 in the same cycle -> fault_code=1 (priority over conflict).
